trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/tcore_param.sv | 36 +++
 rtl/trap_cause_enc.sv | 22 ++
 rtl/trap_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tcore_param.sv
// Shared core types: exception kinds, trap FSM states and mcause encodings.
package tcore_param;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        NO_EXCEPTION     = 3'd0,
        INSTR_MISALIGNED = 3'd1,
        ILLEGAL_INSTR    = 3'd2,
        BREAKPOINT       = 3'd3,
        LOAD_MISALIGNED  = 3'd4,
        STORE_MISALIGNED = 3'd5,
        ECALL            = 3'd6
    } exc_type_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } trap_state_e;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_MRET = 1'b1
    } trap_kind_e;

    // Machine-mode synchronous exception codes; interrupt bit is always 0 here.
    localparam logic [XLEN-1:0] MCAUSE_INSTR_MISALIGNED = XLEN'(0);
    localparam logic [XLEN-1:0] MCAUSE_ILLEGAL_INSTR    = XLEN'(2);
    localparam logic [XLEN-1:0] MCAUSE_BREAKPOINT       = XLEN'(3);
    localparam logic [XLEN-1:0] MCAUSE_LOAD_MISALIGNED  = XLEN'(4);
    localparam logic [XLEN-1:0] MCAUSE_STORE_MISALIGNED = XLEN'(6);
    localparam logic [XLEN-1:0] MCAUSE_ECALL            = XLEN'(11);

endpackage

// File: rtl/trap_cause_enc.sv
// Combinational map from the execute-stage exception kind to an mcause value.
module trap_cause_enc
    import tcore_param::*;
(
    input  exc_type_e          exc_type,
    output logic [XLEN-1:0]    mcause
);

    always_comb begin
        mcause = '0;
        case (exc_type)
            INSTR_MISALIGNED: mcause = MCAUSE_INSTR_MISALIGNED;
            ILLEGAL_INSTR:    mcause = MCAUSE_ILLEGAL_INSTR;
            BREAKPOINT:       mcause = MCAUSE_BREAKPOINT;
            LOAD_MISALIGNED:  mcause = MCAUSE_LOAD_MISALIGNED;
            STORE_MISALIGNED: mcause = MCAUSE_STORE_MISALIGNED;
            ECALL:            mcause = MCAUSE_ECALL;
            default:          mcause = '0;
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/MRET sequencer: flush the pipe, strobe the CSR update, redirect the PC.
// Optional MRET return path is enabled by defining TRAP_CTRL_MRET_EN.
module trap_ctrl
    import tcore_param::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  exc_type_e          exc_type_i,
    input  logic [XLEN-1:0]    exc_pc_i,
    input  logic               alu_stall_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    input  logic               mret_i,
    output logic               trap_active_o,
    output logic [XLEN-1:0]    trap_cause_o,
    output logic [XLEN-1:0]    trap_mepc_o,
    output logic               flush_o,
    output logic               stall_o,
    output logic               redirect_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               busy_o
);

    localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] MASK_BIT0  = ~XLEN'(1);
    localparam logic [XLEN-1:0] MASK_MODE  = ~XLEN'(3);

    trap_state_e       state_reg, state_next;
    logic [2:0]        count_reg, count_next;
    logic [XLEN-1:0]   cause_reg, cause_next;
    logic [XLEN-1:0]   pc_reg, pc_next;
    trap_kind_e        kind_reg, kind_next;
    logic [XLEN-1:0]   enc_cause;
    logic              take_exc;
    logic              take_mret;

    trap_cause_enc u_cause_enc (
        .exc_type (exc_type_i),
        .mcause   (enc_cause)
    );

    assign take_exc = (state_reg == IDLE) && (exc_type_i != NO_EXCEPTION) && !alu_stall_i;

`ifdef TRAP_CTRL_MRET_EN
    // Exceptions take priority over a simultaneous MRET.
    assign take_mret = (state_reg == IDLE) && (exc_type_i == NO_EXCEPTION)
                       && mret_i && !alu_stall_i;
`else
    logic unused_mret;
    assign take_mret   = 1'b0;
    assign unused_mret = mret_i ^ (^mepc_i);
`endif

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        cause_next = cause_reg;
        pc_next    = pc_reg;
        kind_next  = kind_reg;
        case (state_reg)
            IDLE: begin
                if (take_exc) begin
                    state_next = FLUSH;
                    count_next = FLUSH_LOAD;
                    cause_next = enc_cause;
                    pc_next    = exc_pc_i & MASK_BIT0;
                    kind_next  = KIND_TRAP;
                end else if (take_mret) begin
                    state_next = FLUSH;
                    count_next = FLUSH_LOAD;
                    kind_next  = KIND_MRET;
                end
            end
            FLUSH: begin
                if (count_reg == 3'd0) begin
                    state_next = (kind_reg == KIND_MRET) ? REDIRECT : COMMIT;
                end else begin
                    count_next = count_reg - 3'd1;
                end
            end
            COMMIT:   state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            count_reg <= 3'd0;
            cause_reg <= '0;
            pc_reg    <= '0;
            kind_reg  <= KIND_TRAP;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            cause_reg <= cause_next;
            pc_reg    <= pc_next;
            kind_reg  <= kind_next;
        end
    end

    // Outputs decode purely from state so an async reset zeroes them at once.
    always_comb begin
        trap_active_o = 1'b0;
        trap_cause_o  = '0;
        trap_mepc_o   = '0;
        flush_o       = 1'b0;
        stall_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        busy_o        = (state_reg != IDLE);
        case (state_reg)
            FLUSH: begin
                flush_o = 1'b1;
                stall_o = 1'b1;
            end
            COMMIT: begin
                trap_active_o = 1'b1;
                trap_cause_o  = cause_reg;
                trap_mepc_o   = pc_reg;
                stall_o       = 1'b1;
            end
            REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = (kind_reg == KIND_MRET) ? (mepc_i & MASK_BIT0)
                                                        : (mtvec_i & MASK_MODE);
            end
            default: ;
        endcase
    end

endmodule
